// File: rtl/stopwatch_pkg.sv
// Shared widths, default terminal values and the time record for the stopwatch core.
package stopwatch_pkg;

  localparam int unsigned DECS_W = 7;
  localparam int unsigned SECS_W = 6;
  localparam int unsigned MINS_W = 7;

  localparam int unsigned DEF_DECS_MAX = 99;
  localparam int unsigned DEF_SECS_MAX = 59;
  localparam int unsigned DEF_MINS_MAX = 99;

  typedef struct packed {
    logic [MINS_W-1:0] mins;
    logic [SECS_W-1:0] secs;
    logic [DECS_W-1:0] decs;
  } time_t;

endpackage

// File: rtl/stopwatch_logic_if.sv
// Control levels in, displayed time and overflow flag out.
interface stopwatch_logic_if;
  import stopwatch_pkg::*;

  logic              start_stop;
  logic              hold;
  logic [MINS_W-1:0] stopwatch_unit_mins;
  logic [SECS_W-1:0] stopwatch_unit_secs;
  logic [DECS_W-1:0] stopwatch_unit_decs;
  logic              stopwatch_overflow;

  modport master (
    output start_stop,
    output hold,
    input  stopwatch_unit_mins,
    input  stopwatch_unit_secs,
    input  stopwatch_unit_decs,
    input  stopwatch_overflow
  );

  modport slave (
    input  start_stop,
    input  hold,
    output stopwatch_unit_mins,
    output stopwatch_unit_secs,
    output stopwatch_unit_decs,
    output stopwatch_overflow
  );

endinterface

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) counter with synchronous clear; next_o exposes the post-edge value.
module mod_counter #(
  parameter int unsigned MAX   = 9,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] value_o,
  output logic [WIDTH-1:0] next_o,
  output logic             carry_o
);

  logic [WIDTH-1:0] value_q, value_d;
  logic             at_max;

  assign at_max = (value_q == WIDTH'(MAX));

  always_comb begin
    value_d = value_q;
    if (clear_i) begin
      value_d = '0;
    end else if (en_i) begin
      value_d = at_max ? '0 : value_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    value_q <= value_d;
  end

  assign value_o = value_q;
  assign next_o  = value_d;
  assign carry_o = en_i && at_max;

endmodule

// File: rtl/stopwatch_logic.sv
// Stopwatch core: cascaded hundredths/seconds/minutes counters, saturating overflow, lap hold.
module stopwatch_logic
  import stopwatch_pkg::*;
#(
  parameter int unsigned DECS_MAX = DEF_DECS_MAX,
  parameter int unsigned SECS_MAX = DEF_SECS_MAX,
  parameter int unsigned MINS_MAX = DEF_MINS_MAX
) (
  input  logic              CLK_100Hz,
  input  logic              reset_n,
  stopwatch_logic_if.slave  sw
);

  logic              clear;
  logic              run;
  logic              sat;
  logic              en_decs;
  logic              carry_decs;
  logic              carry_secs;
  logic              unused_carry_mins;
  logic [DECS_W-1:0] decs_val, decs_next;
  logic [SECS_W-1:0] secs_val, secs_next;
  logic [MINS_W-1:0] mins_val, mins_next;
  time_t             cnt_next;
  time_t             disp_q, disp_d;
  logic              ovf_q, ovf_d;

  assign clear = !reset_n;
  assign run   = !sw.start_stop;
  assign sat   = (decs_val == DECS_W'(DECS_MAX)) && (secs_val == SECS_W'(SECS_MAX)) &&
                 (mins_val == MINS_W'(MINS_MAX));
  // Full scale freezes the count; the would-be wrap becomes the overflow flag instead.
  assign en_decs = run && !sat;

  mod_counter #(
    .MAX  (DECS_MAX),
    .WIDTH(DECS_W)
  ) u_decs (
    .clk_i  (CLK_100Hz),
    .clear_i(clear),
    .en_i   (en_decs),
    .value_o(decs_val),
    .next_o (decs_next),
    .carry_o(carry_decs)
  );

  mod_counter #(
    .MAX  (SECS_MAX),
    .WIDTH(SECS_W)
  ) u_secs (
    .clk_i  (CLK_100Hz),
    .clear_i(clear),
    .en_i   (carry_decs),
    .value_o(secs_val),
    .next_o (secs_next),
    .carry_o(carry_secs)
  );

  mod_counter #(
    .MAX  (MINS_MAX),
    .WIDTH(MINS_W)
  ) u_mins (
    .clk_i  (CLK_100Hz),
    .clear_i(clear),
    .en_i   (carry_secs),
    .value_o(mins_val),
    .next_o (mins_next),
    .carry_o(unused_carry_mins)
  );

  assign cnt_next = '{mins: mins_next, secs: secs_next, decs: decs_next};

  always_comb begin
    disp_d = disp_q;
    ovf_d  = ovf_q;
    if (clear) begin
      disp_d = '0;
      ovf_d  = 1'b0;
    end else begin
      if (run && sat) begin
        ovf_d = 1'b1;
      end
      // Loading the post-edge count keeps the display in step with the live count.
      if (sw.hold) begin
        disp_d = cnt_next;
      end
    end
  end

  always_ff @(posedge CLK_100Hz) begin
    disp_q <= disp_d;
    ovf_q  <= ovf_d;
  end

  assign sw.stopwatch_unit_mins = disp_q.mins;
  assign sw.stopwatch_unit_secs = disp_q.secs;
  assign sw.stopwatch_unit_decs = disp_q.decs;
  assign sw.stopwatch_overflow  = ovf_q;

endmodule

// File: tb/tb_stopwatch_logic.sv
// Directed bench: full-size stopwatch plus a 2-minute-scale copy that reaches overflow quickly.
module tb_stopwatch_logic;

  logic clk;
  logic rst_n_a;
  logic rst_n_b;
  int   compared;
  int   mismatched;

  stopwatch_logic_if sw_a ();
  stopwatch_logic_if sw_b ();

  stopwatch_logic u_dut_a (
    .CLK_100Hz(clk),
    .reset_n  (rst_n_a),
    .sw       (sw_a.slave)
  );

  stopwatch_logic #(
    .DECS_MAX(99),
    .SECS_MAX(59),
    .MINS_MAX(2)
  ) u_dut_b (
    .CLK_100Hz(clk),
    .reset_n  (rst_n_b),
    .sw       (sw_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int m, input int s, input int d, input int o);
    logic [20:0] obs, exp;
    obs = {sw_a.stopwatch_unit_mins, sw_a.stopwatch_unit_secs, sw_a.stopwatch_unit_decs,
           sw_a.stopwatch_overflow};
    exp = {7'(m), 6'(s), 7'(d), 1'(o)};
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0d:%0d.%0d ovf=%0d expected=%0d:%0d.%0d ovf=%0d", tag,
             sw_a.stopwatch_unit_mins, sw_a.stopwatch_unit_secs, sw_a.stopwatch_unit_decs,
             sw_a.stopwatch_overflow, m, s, d, o);
    end
  endtask

  task automatic chk_b(input string tag, input int m, input int s, input int d, input int o);
    logic [20:0] obs, exp;
    obs = {sw_b.stopwatch_unit_mins, sw_b.stopwatch_unit_secs, sw_b.stopwatch_unit_decs,
           sw_b.stopwatch_overflow};
    exp = {7'(m), 6'(s), 7'(d), 1'(o)};
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0d:%0d.%0d ovf=%0d expected=%0d:%0d.%0d ovf=%0d", tag,
             sw_b.stopwatch_unit_mins, sw_b.stopwatch_unit_secs, sw_b.stopwatch_unit_decs,
             sw_b.stopwatch_overflow, m, s, d, o);
    end
  endtask

  initial begin
    compared        = 0;
    mismatched      = 0;
    rst_n_a         = 1'b0;
    rst_n_b         = 1'b0;
    sw_a.start_stop = 1'b0;
    sw_a.hold       = 1'b1;
    sw_b.start_stop = 1'b0;
    sw_b.hold       = 1'b1;

    step(5);
    chk_a("reset_a", 0, 0, 0, 0);
    chk_b("reset_b", 0, 0, 0, 0);

    rst_n_a         = 1'b1;
    rst_n_b         = 1'b1;
    sw_a.start_stop = 1'b1;
    sw_b.start_stop = 1'b1;
    step(10);
    chk_a("stopped_after_reset", 0, 0, 0, 0);

    sw_a.start_stop = 1'b0;
    sw_b.start_stop = 1'b0;
    step(99);
    chk_a("run_99", 0, 0, 99, 0);
    step(1);
    chk_a("run_100_sec_carry", 0, 1, 0, 0);
    step(5900);
    chk_a("run_6000_min_carry", 1, 0, 0, 0);
    chk_b("b_run_6000", 1, 0, 0, 0);

    // Small instance reaches its full scale 02:59.99 at 17999 edges.
    step(11999);
    chk_b("b_full_scale", 2, 59, 99, 0);
    chk_a("run_17999", 2, 59, 99, 0);
    step(1);
    chk_b("b_overflow_set", 2, 59, 99, 1);
    chk_a("run_18000_no_ovf", 3, 0, 0, 0);
    step(100);
    chk_b("b_overflow_saturated", 2, 59, 99, 1);
    sw_b.start_stop = 1'b1;
    step(5);
    sw_b.start_stop = 1'b0;
    step(5);
    chk_b("b_overflow_sticky", 2, 59, 99, 1);
    rst_n_b = 1'b0;
    step(1);
    chk_b("b_overflow_reset", 0, 0, 0, 0);
    rst_n_b         = 1'b1;
    sw_b.start_stop = 1'b1;

    // 18111 edges elapsed on A; finish the 50000-edge run.
    step(31889);
    chk_a("run_50000", 8, 20, 0, 0);

    sw_a.start_stop = 1'b1;
    sw_a.hold       = 1'b0;
    step(50);
    chk_a("stopped_and_held", 8, 20, 0, 0);
    sw_a.hold       = 1'b1;
    sw_a.start_stop = 1'b0;
    step(1);
    chk_a("resume_first_edge", 8, 20, 1, 0);
    step(49);
    chk_a("resume_50", 8, 20, 50, 0);

    rst_n_a = 1'b0;
    step(1);
    chk_a("reset_mid_run", 0, 0, 0, 0);
    rst_n_a = 1'b1;
    step(500);
    chk_a("lap_start", 0, 5, 0, 0);
    sw_a.hold = 1'b0;
    step(300);
    chk_a("lap_frozen", 0, 5, 0, 0);
    sw_a.hold = 1'b1;
    step(1);
    chk_a("lap_release", 0, 8, 1, 0);

    rst_n_a = 1'b0;
    step(1);
    rst_n_a = 1'b1;
    step(4217);
    chk_a("run_4217", 0, 42, 17, 0);
    sw_a.hold = 1'b0;
    rst_n_a   = 1'b0;
    step(1);
    chk_a("reset_while_held", 0, 0, 0, 0);
    rst_n_a   = 1'b1;
    sw_a.hold = 1'b1;
    step(1);
    chk_a("restart_first_edge", 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
